input_conditioner: RTL and testbench

Front-end stage that drives the pet state machine (`fsm_states`). It synchronises and debounces the raw push-buttons and sensor lines. It emits single-cycle `feeding`, `healing`, `change_state` and `test` pulses, plus clean `light_out` and `echo_sig` levels, all registered and aligned to `clk`. Every output connects directly to the same-named input of `fsm_states`.

---
 rtl/input_conditioner_pkg.sv | 20 ++
 rtl/input_conditioner_debounce_ch.sv | 53 +++++
 rtl/input_conditioner.sv | 130 +++++++++++++
 tb/tb_input_conditioner.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/input_conditioner_pkg.sv
// Shared constants and change-button FSM encoding for input_conditioner.
package input_conditioner_pkg;

  localparam int unsigned DEF_DEBOUNCE_CYCLES   = 1000000;
  localparam int unsigned DEF_LONG_PRESS_CYCLES = 250000000;

  localparam int unsigned NUM_CH    = 5;
  localparam int unsigned CH_FEED   = 0;
  localparam int unsigned CH_HEAL   = 1;
  localparam int unsigned CH_CHANGE = 2;
  localparam int unsigned CH_LIGHT  = 3;
  localparam int unsigned CH_ECHO   = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HELD  = 2'd1,
    ST_FIRED = 2'd2
  } chg_state_e;

endpackage

// File: rtl/input_conditioner_debounce_ch.sv
// One input channel: 2-FF synchroniser, counting debouncer and rise strobe.
module debounce_ch
  import input_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic q_o,
  output logic rise_o
);

  localparam int unsigned   CW       = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          q_q, q_d, qprev_q;
  logic [CW-1:0] cnt_q, cnt_d;

  // Counter restarts whenever the synchronised input agrees with the stable value.
  always_comb begin
    q_d   = q_q;
    cnt_d = '0;
    if (sync2_q != q_q) begin
      if (cnt_q == CNT_LAST) begin
        q_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      q_q     <= 1'b0;
      qprev_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      q_q     <= q_d;
      qprev_q <= q_q;
      cnt_q   <= cnt_d;
    end
  end

  assign q_o    = q_q;
  assign rise_o = q_q & ~qprev_q;

endmodule

// File: rtl/input_conditioner.sv
// Button/sensor front end for fsm_states: five debounce channels, registered outputs,
// and a short/long-press FSM on btn_change enabled by INPUT_COND_LONGPRESS_EN.
module input_conditioner
  import input_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned LONG_PRESS_CYCLES = DEF_LONG_PRESS_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_feed,
  input  logic btn_heal,
  input  logic btn_change,
  input  logic light_raw,
  input  logic echo_raw,
  output logic feeding,
  output logic healing,
  output logic change_state,
  output logic test,
  output logic light_out,
  output logic echo_sig
);

  logic [NUM_CH-1:0] raw, q, rise;

  assign raw = {echo_raw, light_raw, btn_change, btn_heal, btn_feed};

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .clk    (clk),
      .rst    (rst),
      .raw_i  (raw[i]),
      .q_o    (q[i]),
      .rise_o (rise[i])
    );
  end

  logic feed_q, heal_q, change_q, test_q, light_q, echo_q;
  logic change_d, test_d;

`ifdef INPUT_COND_LONGPRESS_EN
  localparam int unsigned   HW        = $clog2(LONG_PRESS_CYCLES);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_PRESS_CYCLES - 1);

  chg_state_e    state_q, state_d;
  logic [HW-1:0] hold_q, hold_d, hold_inc;

  logic unused_ch;
  assign unused_ch = ^{q[CH_FEED], q[CH_HEAL], rise[CH_LIGHT], rise[CH_ECHO]};

  assign hold_inc = hold_q + 1'b1;

  // test fires on the edge where hold becomes LONG_PRESS_CYCLES-1; a release seen
  // in the same cycle wins and is reported as a short press.
  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    change_d = 1'b0;
    test_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rise[CH_CHANGE]) begin
          state_d = ST_HELD;
          hold_d  = '0;
        end
      end
      ST_HELD: begin
        if (!q[CH_CHANGE]) begin
          change_d = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          hold_d = hold_inc;
          if (hold_inc == HOLD_LAST) begin
            test_d  = 1'b1;
            state_d = ST_FIRED;
          end
        end
      end
      ST_FIRED: begin
        if (!q[CH_CHANGE]) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end
`else
  logic unused_ch;
  assign unused_ch = ^{q[CH_FEED], q[CH_HEAL], q[CH_CHANGE], rise[CH_LIGHT], rise[CH_ECHO]};

  assign change_d = rise[CH_CHANGE];
  assign test_d   = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      feed_q   <= 1'b0;
      heal_q   <= 1'b0;
      change_q <= 1'b0;
      test_q   <= 1'b0;
      light_q  <= 1'b0;
      echo_q   <= 1'b0;
    end else begin
      feed_q   <= rise[CH_FEED];
      heal_q   <= rise[CH_HEAL];
      change_q <= change_d;
      test_q   <= test_d;
      light_q  <= q[CH_LIGHT];
      echo_q   <= q[CH_ECHO];
    end
  end

  assign feeding      = feed_q;
  assign healing      = heal_q;
  assign change_state = change_q;
  assign test         = test_q;
  assign light_out    = light_q;
  assign echo_sig     = echo_q;

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner with DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=20.
module tb_input_conditioner;

  logic clk = 1'b0;
  logic rst;
  logic btn_feed, btn_heal, btn_change, light_raw, echo_raw;
  logic feeding, healing, change_state, test, light_out, echo_sig;

  input_conditioner #(
    .DEBOUNCE_CYCLES   (4),
    .LONG_PRESS_CYCLES (20)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_feed     (btn_feed),
    .btn_heal     (btn_heal),
    .btn_change   (btn_change),
    .light_raw    (light_raw),
    .echo_raw     (echo_raw),
    .feeding      (feeding),
    .healing      (healing),
    .change_state (change_state),
    .test         (test),
    .light_out    (light_out),
    .echo_sig     (echo_sig)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  int cyc;
  int cnt   [6];
  int first [6];
  int excl_viol = 0;

  // index: 0 feeding, 1 healing, 2 change_state, 3 test, 4 light_out, 5 echo_sig
  function automatic logic [5:0] outs();
    return {echo_sig, light_out, test, change_state, healing, feeding};
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic clr();
    cyc = 0;
    for (int i = 0; i < 6; i++) begin
      cnt[i]   = 0;
      first[i] = -1;
    end
  endtask

  // Sample on the falling edge; cyc==n means "just after rising edge n".
  task automatic tick();
    logic [5:0] o;
    @(negedge clk);
    cyc++;
    o = outs();
    for (int i = 0; i < 6; i++) begin
      if (o[i]) begin
        cnt[i]++;
        if (first[i] < 0) first[i] = cyc;
      end
    end
    if (change_state && test) excl_viol++;
  endtask

  initial begin
    rst = 1'b1;
    btn_feed = 0; btn_heal = 0; btn_change = 0; light_raw = 0; echo_raw = 0;
    clr();
    repeat (3) tick();
    chk("reset_outs", int'(outs()), 0);
    rst = 1'b0;

    clr();
    repeat (50) tick();
    chk("quiet_pulses", cnt[0] + cnt[1] + cnt[2] + cnt[3] + cnt[4] + cnt[5], 0);

    // feed held 10 cycles: first sampled at edge 1, pulse at edge 7
    clr();
    btn_feed = 1;
    repeat (10) tick();
    btn_feed = 0;
    repeat (20) tick();
    chk("feed10_count", cnt[0], 1);
    chk("feed10_first", first[0], 7);
    chk("feed10_heal_quiet", cnt[1], 0);

    // 3-cycle glitch is shorter than the debounce window
    clr();
    btn_feed = 1;
    repeat (3) tick();
    btn_feed = 0;
    repeat (20) tick();
    chk("feed3_count", cnt[0], 0);

    // simultaneous feed and heal
    clr();
    btn_feed = 1; btn_heal = 1;
    repeat (10) tick();
    btn_feed = 0; btn_heal = 0;
    repeat (20) tick();
    chk("both_feed_count", cnt[0], 1);
    chk("both_heal_count", cnt[1], 1);
    chk("both_feed_first", first[0], 7);
    chk("both_heal_first", first[1], 7);

    // light level: high edges 7..16
    clr();
    light_raw = 1;
    repeat (10) tick();
    light_raw = 0;
    repeat (20) tick();
    chk("light_first", first[4], 7);
    chk("light_count", cnt[4], 10);

    // echo exactly 4 cycles passes, 3 cycles does not
    clr();
    echo_raw = 1;
    repeat (4) tick();
    echo_raw = 0;
    repeat (20) tick();
    chk("echo4_first", first[5], 7);
    chk("echo4_count", cnt[5], 4);
    clr();
    echo_raw = 1;
    repeat (3) tick();
    echo_raw = 0;
    repeat (20) tick();
    chk("echo3_count", cnt[5], 0);

`ifdef INPUT_COND_LONGPRESS_EN
    // short press: q falls at edge 14, change_state at edge 15
    clr();
    btn_change = 1;
    repeat (8) tick();
    btn_change = 0;
    repeat (20) tick();
    chk("short_change_count", cnt[2], 1);
    chk("short_change_first", first[2], 15);
    chk("short_test_count", cnt[3], 0);

    // long press: q rises edge 6, test 20 cycles later at edge 26
    clr();
    btn_change = 1;
    repeat (40) tick();
    btn_change = 0;
    repeat (20) tick();
    chk("long_test_count", cnt[3], 1);
    chk("long_test_first", first[3], 26);
    chk("long_change_count", cnt[2], 0);

    // reset in HELD with hold=10 (after edge 17)
    clr();
    btn_change = 1;
    repeat (17) tick();
    chk("midhold_pre_pulses", cnt[2] + cnt[3], 0);
    rst = 1'b1;
    repeat (3) tick();
    chk("midhold_rst_outs", int'(outs()), 0);
    rst = 1'b0;
    clr();
    repeat (40) tick();
    chk("midhold_test_count", cnt[3], 1);
    chk("midhold_test_first", first[3], 26);
    chk("midhold_change_count", cnt[2], 0);
    btn_change = 0;
    clr();
    repeat (20) tick();
    chk("midhold_release_change", cnt[2], 0);
`else
    // press edge pulse only, test never fires
    clr();
    btn_change = 1;
    repeat (40) tick();
    btn_change = 0;
    repeat (20) tick();
    chk("nomacro_change_count", cnt[2], 1);
    chk("nomacro_change_first", first[2], 7);
    chk("nomacro_test_count", cnt[3], 0);
`endif

    chk("mutual_exclusion", excl_viol, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
